// File: rtl/counter_pkg.sv
// Shared timing constants and the count-direction encoding for the counter
// family (modulo counters, FND scan timing).
package counter_pkg;

    localparam int SYS_CLK_HZ = 100_000_000;
    localparam int DIV_10HZ   = SYS_CLK_HZ / 10;
    localparam int DIV_1KHZ   = SYS_CLK_HZ / 1000;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/mod_counter_tick_tick_gen.sv
// Single-clock prescaler: emits a one-cycle enable strobe (combinational, valid
// in the cycle whose rising edge completes a TICK_DIV-long interval).
module tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the if/else leaves it unassigned and no latch is inferred.
        pre_d = pre_q;
        tick  = 1'b0;
        if (restart) begin
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end

endmodule : tick_gen

// File: rtl/mod_counter_tick.sv
// Modulo-MOD up/down counter stepped by an integrated prescaler; count, tick
// and wrap are all registered and share the system clock.
module mod_counter_tick
    import counter_pkg::*;
#(
    parameter int TICK_DIV = DIV_10HZ,
    parameter int MOD      = 10_000,
    localparam int CW      = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          down,
    output logic [CW-1:0] count,
    output logic          tick,
    output logic          wrap
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(MOD - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          step;
    dir_e          dir;

    assign dir = dir_e'(down);

    // clear and load both restart the interval so the next step is a full
    // TICK_DIV cycles away; a load on a step edge therefore swallows that step.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (run),
        .restart (clear | load),
        .tick    (step)
    );

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > COUNT_MAX) ? COUNT_MAX : load_val;
        end else if (step) begin
            tick_d = 1'b1;
            if (dir == DIR_UP) begin
                if (count_q == COUNT_MAX) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = COUNT_MAX;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous
    // reset; only these few flops exist, so all of them are reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule : mod_counter_tick

// File: tb/tb_mod_counter_tick.sv
// Two instances (TICK_DIV=4/MOD=10 and TICK_DIV=1/MOD=3) on shared stimulus,
// compared each cycle against an integer model of the counting rules.
module tb_mod_counter_tick;

    localparam int DIV_A = 4;
    localparam int MOD_A = 10;
    localparam int DIV_B = 1;
    localparam int MOD_B = 3;

    logic       clk = 1'b0;
    logic       reset, run, clear, load, down;
    logic [3:0] load_val_a;
    logic [1:0] load_val_b;
    logic [3:0] count_a;
    logic [1:0] count_b;
    logic       tick_a, wrap_a, tick_b, wrap_b;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state, index 0 = instance A, 1 = instance B.
    int m_div[2] = '{DIV_A, DIV_B};
    int m_mod[2] = '{MOD_A, MOD_B};
    int m_pre[2];
    int m_cnt[2];
    int m_tick[2];
    int m_wrap[2];

    always #5 clk = ~clk;

    mod_counter_tick #(.TICK_DIV(DIV_A), .MOD(MOD_A)) dut_a (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .load(load),
        .load_val(load_val_a), .down(down),
        .count(count_a), .tick(tick_a), .wrap(wrap_a)
    );

    mod_counter_tick #(.TICK_DIV(DIV_B), .MOD(MOD_B)) dut_b (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .load(load),
        .load_val(load_val_b), .down(down),
        .count(count_b), .tick(tick_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge(input int i, input int lv);
        if (reset || clear) begin
            m_pre[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
        end else if (load) begin
            m_cnt[i]  = (lv < m_mod[i]) ? lv : m_mod[i] - 1;
            m_pre[i]  = 0; m_tick[i] = 0; m_wrap[i] = 0;
        end else if (run && m_pre[i] == m_div[i] - 1) begin
            m_pre[i]  = 0;
            m_tick[i] = 1;
            if (!down) begin
                m_wrap[i] = (m_cnt[i] == m_mod[i] - 1) ? 1 : 0;
                m_cnt[i]  = (m_cnt[i] + 1) % m_mod[i];
            end else begin
                m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
                m_cnt[i]  = (m_cnt[i] + m_mod[i] - 1) % m_mod[i];
            end
        end else begin
            if (run) m_pre[i] = m_pre[i] + 1;
            m_tick[i] = 0; m_wrap[i] = 0;
        end
    endfunction

    // One rising edge: advance the model with the inputs the DUT sampled,
    // then compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge(0, int'(load_val_a));
        model_edge(1, int'(load_val_b));
        #1;
        check("count_a", int'(count_a), m_cnt[0]);
        check("tick_a",  int'(tick_a),  m_tick[0]);
        check("wrap_a",  int'(wrap_a),  m_wrap[0]);
        check("count_b", int'(count_b), m_cnt[1]);
        check("tick_b",  int'(tick_b),  m_tick[1]);
        check("wrap_b",  int'(wrap_b),  m_wrap[1]);
    endtask

    task automatic set_lv(input int v);
        load_val_a = 4'(v);
        load_val_b = 2'(v);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; clear = 1'b0; load = 1'b0; down = 1'b0;
        set_lv(0);
        for (int i = 0; i < 2; i++) begin
            m_pre[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
        end
        cycle();
        cycle();
        check("reset_count", int'(count_a), 0);
        check("reset_tick",  int'(tick_a),  0);

        // Count up from reset: a step every 4th edge, wrap on the 10th step.
        reset = 1'b0; run = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (c == 4) check("first_step_count", int'(count_a), 1);
            if (c == 39) check("no_wrap_before", int'(wrap_a), 0);
        end
        check("wrap_at_40_count", int'(count_a), 0);
        check("wrap_at_40_wrap",  int'(wrap_a),  1);

        // Count down from 0: 9 with wrap, then 8, 7.
        down = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 4) check("down_wrap_count", int'(count_a), 9);
            if (c == 4) check("down_wrap_wrap",  int'(wrap_a),  1);
        end
        check("down_count_7", int'(count_a), 7);

        // Pause at pre=2 for 7 clocks; the next step is 2 clocks after resume.
        down = 1'b0; reset = 1'b1; cycle(); reset = 1'b0;
        cycle(); cycle();
        run = 1'b0;
        for (int c = 0; c < 7; c++) cycle();
        run = 1'b1;
        cycle();
        check("resume_tick_early", int'(tick_a), 0);
        cycle();
        check("resume_tick", int'(tick_a), 1);

        // Load on a scheduled step edge: load wins, then a step 4 clocks later.
        for (int c = 0; c < 8 && m_pre[0] != DIV_A - 1; c++) cycle();
        load = 1'b1; set_lv(7);
        cycle();
        load = 1'b0;
        check("load_on_step_count", int'(count_a), 7);
        check("load_on_step_tick",  int'(tick_a),  0);
        for (int c = 0; c < 4; c++) cycle();
        check("after_load_count", int'(count_a), 8);
        check("after_load_tick",  int'(tick_a),  1);
        load = 1'b1; set_lv(15);
        cycle();
        load = 1'b0;
        check("load_saturate", int'(count_a), 9);

        // clear beats load with run high.
        clear = 1'b1; load = 1'b1; set_lv(5);
        cycle();
        clear = 1'b0; load = 1'b0;
        check("clear_over_load", int'(count_a), 0);

        // Randomized traffic, including mid-interval reset and direction flips.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(99) < 1);
            clear = ($urandom_range(99) < 2);
            load  = ($urandom_range(99) < 3);
            run   = ($urandom_range(99) < 85);
            if ($urandom_range(99) < 5) down = ~down;
            set_lv(int'($urandom_range(15)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_mod_counter_tick
